// File: rtl/pp2_pkg.sv
// Shared definitions for the pp2 two-bit controller: opcodes and FSM states.
package pp2_pkg;

  // Two-bit instruction opcodes as stored in the instruction ROM.
  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_JNO = 2'b01;
  localparam logic [1:0] OP_HLT = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  // True for opcodes that need an EXEC cycle after their FETCH.
  function automatic logic needs_exec(input logic [1:0] op);
    return (op == OP_INC) || (op == OP_JNO);
  endfunction

endpackage

// File: rtl/pp2_ctrl.sv
// pp2 controller: fetches two-bit instructions from an external combinational
// ROM addressed by pc, executes INC / JNO, stops on HLT or an illegal opcode.
// Every output is a register (mem_addr is pc itself), so mem_data never
// reaches an output combinationally.
module pp2_ctrl
  import pp2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [1:0]       mem_addr,
  input  logic [1:0]       mem_data,
  output logic [1:0]       acc,
  output logic             ovf,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] cyc_cnt
);

  state_t           state_reg, state_next;
  logic [1:0]       pc_reg, pc_next;
  logic [1:0]       opcode_reg, opcode_next;
  logic [1:0]       acc_reg, acc_next;
  logic             ovf_reg, ovf_next;
  logic             halted_reg, halted_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] cyc_reg;
  logic             busy;

  // Architectural state register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      pc_reg     <= 2'd0;
      opcode_reg <= OP_INC;
      acc_reg    <= 2'd0;
      ovf_reg    <= 1'b0;
      halted_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      opcode_reg <= opcode_next;
      acc_reg    <= acc_next;
      ovf_reg    <= ovf_next;
      halted_reg <= halted_next;
      err_reg    <= err_next;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts on it.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    opcode_next = opcode_reg;
    acc_next    = acc_reg;
    ovf_next    = ovf_reg;
    halted_next = halted_reg;
    err_next    = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        opcode_next = mem_data;
        pc_next     = pc_reg + 2'd1;
        if (needs_exec(mem_data)) begin
          state_next = ST_EXEC;
        end else begin
          // HLT and the illegal opcode both stop; only the latter flags err.
          state_next  = ST_HALT;
          halted_next = 1'b1;
          err_next    = (mem_data == OP_ILL);
        end
      end
      ST_EXEC: begin
        state_next = ST_FETCH;
        if (opcode_reg == OP_INC) begin
          // Three-bit sum: the carry out of the two-bit acc becomes ovf.
          {ovf_next, acc_next} = {1'b0, acc_reg} + 3'd1;
        end else if (opcode_reg == OP_JNO) begin
          // mem_data here is the operand word at the current pc.
          if (!ovf_reg) pc_next = mem_data;
          else          pc_next = pc_reg + 2'd1;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state_reg == ST_FETCH) || (state_reg == ST_EXEC);

  // Busy-cycle counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_reg <= '0;
    end else if (busy && (cyc_reg != {CNT_W{1'b1}})) begin
      cyc_reg <= cyc_reg + CNT_W'(1);
    end
  end

  assign mem_addr = pc_reg;
  assign acc      = acc_reg;
  assign ovf      = ovf_reg;
  assign halted   = halted_reg;
  assign err      = err_reg;
  assign cyc_cnt  = cyc_reg;

endmodule

// File: tb/tb_pp2_ctrl.sv
// Scoreboard bench for pp2_ctrl: an instruction-level program interpreter
// predicts the visible state after every clock edge; a monitor compares.
module tb_pp2_ctrl;
  import pp2_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] rom [4];

  logic [1:0] addr8, data8, acc8, addr4, data4, acc4;
  logic       ovf8, halted8, err8, ovf4, halted4, err4;
  logic [7:0] cyc8;
  logic [3:0] cyc4;

  always #5 clk = ~clk;

  assign data8 = rom[addr8];
  assign data4 = rom[addr4];

  pp2_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_addr(addr8), .mem_data(data8),
    .acc(acc8), .ovf(ovf8), .halted(halted8), .err(err8), .cyc_cnt(cyc8)
  );

  pp2_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_addr(addr4), .mem_data(data4),
    .acc(acc4), .ovf(ovf4), .halted(halted4), .err(err4), .cyc_cnt(cyc4)
  );

  typedef struct {
    logic [1:0] addr;
    logic [1:0] acc;
    logic       ovf;
    logic       halted;
    logic       err;
    int         cnt;
  } snap_t;

  snap_t sb[$];
  snap_t trace[$];
  int    checks = 0;
  int    errors = 0;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Interpret the program in rom: one entry per clock edge after the edge
  // that samples start. Two cycles per INC/JNO, one for a stopping fetch.
  task automatic build_trace(input int n);
    int         pc, a, o, h, e, c, op, s;
    snap_t      t;
    pc = 0; a = 0; o = 0; h = 0; e = 0; c = 0;
    trace.delete();
    while (trace.size() < n) begin
      if (h == 0) begin
        op = int'(rom[pc]);
        pc = (pc + 1) % 4;
        c++;
        if (op >= 2) begin
          h = 1;
          e = (op == 3) ? 1 : 0;
        end else begin
          t = '{2'(pc), 2'(a), 1'(o), 1'(h), 1'(e), c};
          trace.push_back(t);
          c++;
          if (op == 0) begin
            s = a + 1;
            o = (s > 3) ? 1 : 0;
            a = s % 4;
          end else if (o == 0) begin
            pc = int'(rom[pc]);
          end else begin
            pc = (pc + 1) % 4;
          end
        end
      end
      t = '{2'(pc), 2'(a), 1'(o), 1'(h), 1'(e), c};
      if (trace.size() < n) trace.push_back(t);
    end
  endtask

  // Compare DUT outputs against the oldest expectation, away from the edge.
  task automatic monitor();
    snap_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({addr8, acc8, ovf8, halted8, err8} !== {e.addr, e.acc, e.ovf, e.halted, e.err} ||
            cyc8 !== 8'(sat(e.cnt, 255))) begin
          errors++;
          $display("FAIL snap8 got addr=%0d acc=%0d ovf=%0b halted=%0b err=%0b cyc=%0d expected addr=%0d acc=%0d ovf=%0b halted=%0b err=%0b cyc=%0d at %0t",
                   addr8, acc8, ovf8, halted8, err8, cyc8,
                   e.addr, e.acc, e.ovf, e.halted, e.err, sat(e.cnt, 255), $time);
        end
        chk("cyc4", 32'(cyc4), 32'(sat(e.cnt, 15)));
      end
    end
  endtask

  // Let the monitor consume everything pushed, with a bounded wait.
  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Assert reset between edges and check outputs clear at once.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_vals", 32'({addr8, acc8, ovf8, halted8, err8}), 32'd0);
    chk("rst_cyc", 32'({cyc8, cyc4}), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Idle cycles (start low), one start pulse, then n_run predicted cycles.
  task automatic run(input int n_idle, input int n_run, input bit rnd_start);
    snap_t z;
    z = '{2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 0};
    build_trace(n_run);
    for (int i = 0; i < n_idle; i++) begin
      start = 1'b0;
      @(posedge clk);
      sb.push_back(z);
      #1;
    end
    start = 1'b1;
    @(posedge clk);
    sb.push_back(z);
    #1;
    for (int i = 0; i < n_run; i++) begin
      start = rnd_start ? 1'($urandom) : 1'b0;
      @(posedge clk);
      sb.push_back(trace[i]);
      #1;
      $display("cycle %0d: addr=%0d acc=%0d ovf=%0b halted=%0b err=%0b cyc=%0d",
               i, addr8, acc8, ovf8, halted8, err8, cyc8);
    end
    start = 1'b0;
    wait_drain();
  endtask

  initial begin
    fork
      monitor();
    join_none
    rom = '{OP_INC, OP_JNO, 2'b00, OP_HLT};
    #12;
    do_reset();

    // Counting loop that wraps acc, falls through the JNO and halts.
    run(3, 25, 1'b1);
    chk("p1_cyc", 32'(cyc8), 32'd17);
    chk("p1_flags", 32'({halted8, err8, ovf8}), 32'b101);
    chk("p1_acc", 32'(acc8), 32'd0);

    // Straight-line INC loop: pc wraps, never halts, both counters saturate.
    do_reset();
    rom = '{OP_INC, OP_INC, OP_INC, OP_INC};
    run(2, 300, 1'b1);
    chk("p2_halted", 32'(halted8), 32'd0);
    chk("p2_cyc8", 32'(cyc8), 32'd255);
    chk("p2_cyc4", 32'(cyc4), 32'd15);

    // Illegal opcode first: halt with err after two edges.
    do_reset();
    rom = '{OP_ILL, OP_INC, OP_JNO, OP_INC};
    run(1, 6, 1'b1);
    chk("p3_flags", 32'({halted8, err8}), 32'b11);
    chk("p3_acc", 32'(acc8), 32'd0);

    // Reset while executing the JNO; afterwards the FSM must wait for start.
    do_reset();
    rom = '{OP_INC, OP_JNO, 2'b00, OP_HLT};
    run(0, 3, 1'b0);
    do_reset();
    run(6, 25, 1'b0);
    chk("p4_cyc", 32'(cyc8), 32'd17);

    // Random programs with random start noise after the start pulse.
    for (int p = 0; p < 15; p++) begin
      do_reset();
      for (int i = 0; i < 4; i++) rom[i] = 2'($urandom);
      run(int'($urandom_range(0, 3)), int'($urandom_range(10, 60)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
